// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute steps around the shared ALU.
// Moore outputs are registered from the next state; MemReady/Zero gating is applied at the pins.
module mips_multicycle_ctrl #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       iord_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_control_o,
    output logic [1:0] pc_src_o,
    output logic       pc_en_o,
    output logic       instr_done_o,
    output logic       illegal_op_o
);
    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecute, StAluWb, StBranch, StAddiEx, StAddiWb, StJump
    } state_e;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b100;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b110;
    localparam logic [2:0] AluMul = 3'b101;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpJ    = 6'b000010;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       done;
        logic       fetch;
        logic       decode;
        logic       execute;
        logic       mem_wr_st;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        c.alu_control = AluAdd;
        case (s)
            StFetch:    begin c.alu_src_b = 2'b01; c.fetch = 1'b1; end
            StDecode:   begin c.alu_src_b = 2'b11; c.decode = 1'b1; end
            StMemAdr:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            StMemRead:  c.iord = 1'b1;
            StMemWb:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
            StMemWrite: begin c.iord = 1'b1; c.mem_write = 1'b1; c.mem_wr_st = 1'b1; end
            StExecute:  begin c.alu_src_a = 1'b1; c.execute = 1'b1; end
            StAluWb:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; end
            StBranch: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = AluSub;
                c.pc_src      = 2'b01;
                c.branch      = 1'b1;
                c.done        = 1'b1;
            end
            StAddiEx:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            StAddiWb:   begin c.reg_write = 1'b1; c.done = 1'b1; end
            StJump:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.done = 1'b1; end
            default:    ;
        endcase
        return c;
    endfunction

    // {legal, alu code} for an R-type funct field
    function automatic logic [3:0] funct_decode(input logic [5:0] f);
        case (f)
            6'b100000: return {1'b1, AluAdd};
            6'b100010: return {1'b1, AluSub};
            6'b100100: return {1'b1, AluAnd};
            6'b100101: return {1'b1, AluOr};
            6'b101010: return {1'b1, AluSlt};
            6'b011000: return {MUL_EN, AluMul};
            default:   return {1'b0, AluAdd};
        endcase
    endfunction

    state_e     state_q, state_d;
    ctrl_t      ctrl_q;
    logic       is_sw_q, is_sw_d;
    logic [3:0] funct_dec;
    logic       op_legal;

    assign funct_dec = funct_decode(funct_i);

    always_comb begin
        op_legal = 1'b0;
        case (op_i)
            OpR:                              op_legal = funct_dec[3];
            OpLw, OpSw, OpBeq, OpAddi, OpJ:   op_legal = 1'b1;
            default:                          op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = StFetch;
        is_sw_d = is_sw_q;
        unique case (state_q)
            StFetch:    state_d = mem_ready_i ? StDecode : StFetch;
            StDecode: begin
                is_sw_d = (op_i == OpSw);
                case (op_i)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = funct_dec[3] ? StExecute : StFetch;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = is_sw_q ? StMemWrite : StMemRead;
            StMemRead:  state_d = mem_ready_i ? StMemWb : StMemRead;
            StMemWrite: state_d = mem_ready_i ? StFetch : StMemWrite;
            StExecute:  state_d = StAluWb;
            StAddiEx:   state_d = StAddiWb;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            ctrl_q  <= state_ctrl(StFetch);
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
            is_sw_q <= is_sw_d;
        end
    end

    // FETCH strobes are masked by rst_n so nothing loads while reset is held
    assign ir_write_o    = ctrl_q.fetch & mem_ready_i & rst_n;
    assign pc_en_o       = ((ctrl_q.fetch & mem_ready_i) | ctrl_q.pc_write
                           | (ctrl_q.branch & zero_i)) & rst_n;
    assign iord_o        = ctrl_q.iord;
    assign mem_write_o   = ctrl_q.mem_write;
    assign reg_dst_o     = ctrl_q.reg_dst;
    assign mem_to_reg_o  = ctrl_q.mem_to_reg;
    assign reg_write_o   = ctrl_q.reg_write;
    assign alu_src_a_o   = ctrl_q.alu_src_a;
    assign alu_src_b_o   = ctrl_q.alu_src_b;
    assign alu_control_o = ctrl_q.execute ? funct_dec[2:0] : ctrl_q.alu_control;
    assign pc_src_o      = ctrl_q.pc_src;
    assign instr_done_o  = ctrl_q.done | (ctrl_q.mem_wr_st & mem_ready_i);
    assign illegal_op_o  = ctrl_q.decode & ~op_legal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected control vectors are queued with the
// stimulus and compared against two instances (MUL enabled and disabled).
module tb_mips_multicycle_ctrl;
    typedef struct packed {
        logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctl;
        logic [1:0] pc_src;
        logic       pc_en, done, illegal;
    } vec_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       rdy;
        logic       z;
    } stim_t;

    localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5, S_EX = 6;
    localparam int S_AWB = 7, S_BR = 8, S_AE = 9, S_AW = 10, S_J = 11;
    localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b100, A_MUL = 3'b101;

    logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = '0, funct = '0;

    logic iord1, mw1, irw1, rd1, m2r1, rw1, asa1, pce1, dn1, ill1;
    logic [1:0] asb1, pcs1;
    logic [2:0] alu1;
    logic iord2, mw2, irw2, rd2, m2r2, rw2, asa2, pce2, dn2, ill2;
    logic [1:0] asb2, pcs2;
    logic [2:0] alu2;

    vec_t v1, v2, o1, o2;
    assign v1 = {iord1, mw1, irw1, rd1, m2r1, rw1, asa1, asb1, alu1, pcs1, pce1, dn1, ill1};
    assign v2 = {iord2, mw2, irw2, rd2, m2r2, rw2, asa2, asb2, alu2, pcs2, pce2, dn2, ill2};

    stim_t stim_q[$];
    vec_t  exp1_q[$];
    vec_t  exp2_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .iord_o(iord1), .mem_write_o(mw1), .ir_write_o(irw1),
        .reg_dst_o(rd1), .mem_to_reg_o(m2r1), .reg_write_o(rw1), .alu_src_a_o(asa1),
        .alu_src_b_o(asb1), .alu_control_o(alu1), .pc_src_o(pcs1), .pc_en_o(pce1),
        .instr_done_o(dn1), .illegal_op_o(ill1)
    );

    mips_multicycle_ctrl #(.MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .iord_o(iord2), .mem_write_o(mw2), .ir_write_o(irw2),
        .reg_dst_o(rd2), .mem_to_reg_o(m2r2), .reg_write_o(rw2), .alu_src_a_o(asa2),
        .alu_src_b_o(asb2), .alu_control_o(alu2), .pc_src_o(pcs2), .pc_en_o(pce2),
        .instr_done_o(dn2), .illegal_op_o(ill2)
    );

    // Expected outputs for one cycle in a given state, straight from the state table
    function automatic vec_t ev(input int st, input logic rdy, input logic z,
                                input logic [2:0] alu, input logic ill);
        vec_t v;
        v = '0;
        v.alu_ctl = A_ADD;
        case (st)
            S_F:   begin v.alu_src_b = 2'b01; v.ir_write = rdy; v.pc_en = rdy; end
            S_D:   begin v.alu_src_b = 2'b11; v.illegal = ill; end
            S_MA:  begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; end
            S_MR:  v.iord = 1'b1;
            S_MWB: begin v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.done = 1'b1; end
            S_MW:  begin v.iord = 1'b1; v.mem_write = 1'b1; v.done = rdy; end
            S_EX:  begin v.alu_src_a = 1'b1; v.alu_ctl = alu; end
            S_AWB: begin v.reg_write = 1'b1; v.reg_dst = 1'b1; v.done = 1'b1; end
            S_BR: begin
                v.alu_src_a = 1'b1; v.alu_ctl = A_SUB; v.pc_src = 2'b01;
                v.pc_en = z; v.done = 1'b1;
            end
            S_AE:  begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; end
            S_AW:  begin v.reg_write = 1'b1; v.done = 1'b1; end
            S_J:   begin v.pc_src = 2'b10; v.pc_en = 1'b1; v.done = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic push(input logic [5:0] o, input logic [5:0] f, input logic rdy,
                        input logic z, input int st, input logic [2:0] alu, input logic ill);
        stim_t s;
        s.op = o; s.funct = f; s.rdy = rdy; s.z = z;
        stim_q.push_back(s);
        exp1_q.push_back(ev(st, rdy, z, alu, ill));
        exp2_q.push_back(ev(st, rdy, z, alu, ill));
    endtask

    // Drive one cycle starting just after a rising edge; sample on the falling edge
    task automatic cyc(input stim_t s);
        op = s.op; funct = s.funct; mem_ready = s.rdy; zero = s.z;
        @(negedge clk);
        o1 = v1; o2 = v2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
        repeat (2) @(negedge clk);
        checks += 2;
        if ({irw1, mw1, rw1, pce1, dn1, ill1} !== 6'b0) begin
            failures++;
            $display("FAIL reset dut enables=%b exp=000000", {irw1, mw1, rw1, pce1, dn1, ill1});
        end
        if ({irw2, mw2, rw2, pce2, dn2, ill2} !== 6'b0) begin
            failures++;
            $display("FAIL reset dut_nomul enables=%b exp=000000",
                     {irw2, mw2, rw2, pce2, dn2, ill2});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_r_alu();
        logic [5:0] fs[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        logic [2:0] as[5] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b110};
        vec_t e1, e2;
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            push(6'h00, fs[i], 1'b1, 1'b0, S_F, A_ADD, 1'b0);
            push(6'h00, fs[i], 1'b1, 1'b0, S_D, A_ADD, 1'b0);
            push(6'h00, fs[i], 1'b1, 1'b0, S_EX, as[i], 1'b0);
            push(6'h3f, 6'h3f, 1'b1, 1'b0, S_AWB, A_ADD, 1'b0);
        end
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            checks += 2; n++;
            if (o1 !== e1) begin failures++; $display("FAIL r_alu dut cyc=%0d got=%h exp=%h", n, o1, e1); end
            if (o2 !== e2) begin failures++; $display("FAIL r_alu dut_nomul cyc=%0d got=%h exp=%h", n, o2, e2); end
        end
    endtask

    task automatic test_mul();
        vec_t e1, e2;
        int n = 0;
        push(6'h00, 6'h18, 1'b1, 1'b0, S_F, A_ADD, 1'b0);
        push(6'h00, 6'h18, 1'b1, 1'b0, S_D, A_ADD, 1'b0);
        exp2_q[exp2_q.size() - 1] = ev(S_D, 1'b1, 1'b0, A_ADD, 1'b1);
        push(6'h00, 6'h18, 1'b0, 1'b0, S_EX, A_MUL, 1'b0);
        exp2_q[exp2_q.size() - 1] = ev(S_F, 1'b0, 1'b0, A_ADD, 1'b0);
        push(6'h00, 6'h18, 1'b0, 1'b0, S_AWB, A_ADD, 1'b0);
        exp2_q[exp2_q.size() - 1] = ev(S_F, 1'b0, 1'b0, A_ADD, 1'b0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            checks += 2; n++;
            if (o1 !== e1) begin failures++; $display("FAIL mul dut cyc=%0d got=%h exp=%h", n, o1, e1); end
            if (o2 !== e2) begin failures++; $display("FAIL mul dut_nomul cyc=%0d got=%h exp=%h", n, o2, e2); end
        end
    endtask

    task automatic test_mem_stall();
        vec_t e1, e2;
        int n = 0;
        repeat (3) push(6'h23, 6'h00, 1'b0, 1'b0, S_F, A_ADD, 1'b0);
        push(6'h23, 6'h00, 1'b1, 1'b0, S_F, A_ADD, 1'b0);
        push(6'h23, 6'h00, 1'b1, 1'b0, S_D, A_ADD, 1'b0);
        push(6'h2b, 6'h00, 1'b1, 1'b0, S_MA, A_ADD, 1'b0);  // op change after DECODE ignored
        repeat (2) push(6'h3f, 6'h00, 1'b0, 1'b0, S_MR, A_ADD, 1'b0);
        push(6'h3f, 6'h00, 1'b1, 1'b0, S_MR, A_ADD, 1'b0);
        push(6'h3f, 6'h00, 1'b1, 1'b0, S_MWB, A_ADD, 1'b0);
        push(6'h2b, 6'h00, 1'b1, 1'b0, S_F, A_ADD, 1'b0);
        push(6'h2b, 6'h00, 1'b1, 1'b0, S_D, A_ADD, 1'b0);
        push(6'h23, 6'h00, 1'b1, 1'b0, S_MA, A_ADD, 1'b0);
        push(6'h23, 6'h00, 1'b0, 1'b0, S_MW, A_ADD, 1'b0);
        push(6'h23, 6'h00, 1'b1, 1'b0, S_MW, A_ADD, 1'b0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            checks += 2; n++;
            if (o1 !== e1) begin failures++; $display("FAIL mem dut cyc=%0d got=%h exp=%h", n, o1, e1); end
            if (o2 !== e2) begin failures++; $display("FAIL mem dut_nomul cyc=%0d got=%h exp=%h", n, o2, e2); end
        end
    endtask

    task automatic test_beq();
        vec_t e1, e2;
        int n = 0;
        for (int z = 1; z >= 0; z--) begin
            push(6'h04, 6'h00, 1'b1, z[0], S_F, A_ADD, 1'b0);
            push(6'h04, 6'h00, 1'b1, z[0], S_D, A_ADD, 1'b0);
            push(6'h04, 6'h00, 1'b1, z[0], S_BR, A_ADD, 1'b0);
        end
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            checks += 2; n++;
            if (o1 !== e1) begin failures++; $display("FAIL beq dut cyc=%0d got=%h exp=%h", n, o1, e1); end
            if (o2 !== e2) begin failures++; $display("FAIL beq dut_nomul cyc=%0d got=%h exp=%h", n, o2, e2); end
        end
    endtask

    task automatic test_back_to_back();
        vec_t e1, e2;
        int n = 0;
        push(6'h08, 6'h00, 1'b1, 1'b0, S_F, A_ADD, 1'b0);
        push(6'h08, 6'h00, 1'b1, 1'b0, S_D, A_ADD, 1'b0);
        push(6'h08, 6'h00, 1'b1, 1'b0, S_AE, A_ADD, 1'b0);
        push(6'h02, 6'h00, 1'b1, 1'b0, S_AW, A_ADD, 1'b0);
        push(6'h02, 6'h00, 1'b1, 1'b0, S_F, A_ADD, 1'b0);
        push(6'h02, 6'h00, 1'b1, 1'b0, S_D, A_ADD, 1'b0);
        push(6'h00, 6'h20, 1'b1, 1'b1, S_J, A_ADD, 1'b0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            checks += 2; n++;
            if (o1 !== e1) begin failures++; $display("FAIL b2b dut cyc=%0d got=%h exp=%h", n, o1, e1); end
            if (o2 !== e2) begin failures++; $display("FAIL b2b dut_nomul cyc=%0d got=%h exp=%h", n, o2, e2); end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops[2] = '{6'h3f, 6'h00};
        vec_t e1, e2;
        int n = 0;
        for (int i = 0; i < 2; i++) begin
            push(ops[i], 6'h00, 1'b1, 1'b0, S_F, A_ADD, 1'b0);
            push(ops[i], 6'h00, 1'b1, 1'b0, S_D, A_ADD, 1'b1);
            push(ops[i], 6'h00, 1'b0, 1'b0, S_F, A_ADD, 1'b0);
        end
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            checks += 2; n++;
            if (o1 !== e1) begin failures++; $display("FAIL illegal dut cyc=%0d got=%h exp=%h", n, o1, e1); end
            if (o2 !== e2) begin failures++; $display("FAIL illegal dut_nomul cyc=%0d got=%h exp=%h", n, o2, e2); end
        end
    endtask

    task automatic test_mid_reset();
        vec_t e1, e2, er;
        int n = 0;
        push(6'h23, 6'h00, 1'b1, 1'b0, S_F, A_ADD, 1'b0);
        push(6'h23, 6'h00, 1'b1, 1'b0, S_D, A_ADD, 1'b0);
        push(6'h23, 6'h00, 1'b1, 1'b0, S_MA, A_ADD, 1'b0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            checks += 2; n++;
            if (o1 !== e1) begin failures++; $display("FAIL midrst_pre dut cyc=%0d got=%h exp=%h", n, o1, e1); end
            if (o2 !== e2) begin failures++; $display("FAIL midrst_pre dut_nomul cyc=%0d got=%h exp=%h", n, o2, e2); end
        end
        mem_ready = 1'b0;
        #2;
        er = ev(S_MR, 1'b0, 1'b0, A_ADD, 1'b0);
        checks++;
        if (v1 !== er) begin failures++; $display("FAIL midrst_memread got=%h exp=%h", v1, er); end
        rst_n = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) #1;
            else if (k == 1) @(negedge clk);
            else begin @(posedge clk); #1; end
            checks++;
            if ({irw1, mw1, rw1, pce1, dn1, iord1} !== 6'b0) begin
                failures++;
                $display("FAIL midrst_low step=%0d enables=%b exp=000000", k,
                         {irw1, mw1, rw1, pce1, dn1, iord1});
            end
        end
        rst_n = 1'b1;
        push(6'h02, 6'h00, 1'b1, 1'b0, S_F, A_ADD, 1'b0);
        push(6'h02, 6'h00, 1'b1, 1'b0, S_D, A_ADD, 1'b0);
        push(6'h02, 6'h00, 1'b1, 1'b0, S_J, A_ADD, 1'b0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            checks += 2; n++;
            if (o1 !== e1) begin failures++; $display("FAIL midrst_post dut cyc=%0d got=%h exp=%h", n, o1, e1); end
            if (o2 !== e2) begin failures++; $display("FAIL midrst_post dut_nomul cyc=%0d got=%h exp=%h", n, o2, e2); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_r_alu();
        test_mul();
        test_mem_stall();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
